regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, register word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 2, register address width; depth = 2**ADDR_WIDTH.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port cmd_valid/cmd_ready  input/output  1/1  command handshake.
REQ-006 The block SHALL have port cmd_op  input  1  0 = LOAD (stream into register file), 1 = DUMP (stream out).
REQ-007 The block SHALL have port cmd_base  input  ADDR_WIDTH  first register address.
REQ-008 The block SHALL have port cmd_count  input  ADDR_WIDTH+1  number of words.
REQ-009 The block SHALL have ports in_valid/in_ready/in_data  input/output/input  1/1/DATA_WIDTH  LOAD data stream.
REQ-010 The block SHALL have ports out_valid/out_ready/out_data  output/input/output  1/1/DATA_WIDTH  DUMP data stream.
REQ-011 The block SHALL have ports rf_w_en/rf_w_addr/rf_w_data  output  1/ADDR_WIDTH/DATA_WIDTH  register-file write port.
REQ-012 The block SHALL have ports rf_r_addr/rf_r_data  output/input  ADDR_WIDTH/DATA_WIDTH  register-file read port; read is combinational.
REQ-013 The block SHALL have ports busy/done  output  1/1  operation in progress / one-cycle completion pulse.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, DUMP, DONE.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid && cmd_ready.
REQ-016 On acceptance, ptr <= cmd_base and remaining <= min(cmd_count, 2**ADDR_WIDTH); next state LOAD or DUMP per cmd_op, or DONE if cmd_count == 0.
REQ-017 In LOAD, in_ready SHALL be 1; on in_valid && in_ready, the same cycle SHALL drive rf_w_en=1, rf_w_addr=ptr, rf_w_data=in_data.
REQ-018 rf_w_en SHALL be 0 in every cycle without a LOAD handshake; rf_w_addr/rf_w_data are don't-care when rf_w_en=0.
REQ-019 In DUMP, rf_r_addr SHALL equal ptr, out_valid SHALL be 1, and out_data SHALL equal rf_r_data (zero added latency).
REQ-020 out_data and out_valid SHALL remain stable while out_valid && !out_ready (ptr holds).
REQ-021 Each data handshake SHALL increment ptr modulo 2**ADDR_WIDTH (wrap from max to 0) and decrement remaining.
REQ-022 The handshake with remaining == 1 SHALL move the FSM to DONE on the next edge; no further in_ready/out_valid after it.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done SHALL be 0 in every other state.
REQ-024 busy SHALL be 1 in LOAD, DUMP, DONE and 0 in IDLE.
REQ-025 Back-to-back commands: minimum spacing between accepted commands SHALL be count+2 cycles (count>0) or 2 cycles (count==0).
REQ-026 rf_r_addr SHALL be 0 outside DUMP; in_ready, out_valid SHALL be 0 outside LOAD/DUMP respectively.

Reset
REQ-027 While reset is high at a posedge: state <= IDLE, ptr <= 0, remaining <= 0; reset takes priority over all handshakes.
REQ-028 During a cycle with reset high, rf_w_en, in_ready, out_valid, done SHALL be 0; busy and cmd_ready are state-driven (0/1 after the first reset edge).
REQ-029 Reset mid-LOAD/DUMP SHALL abort the operation; words already written remain in the register file, no partial write occurs in the reset cycle.

Structure
REQ-030 A shared package regfile_seq_pkg SHALL hold the op enum (OP_LOAD, OP_DUMP) and the state enum (IDLE, LOAD, DUMP, DONE).
REQ-031 The block SHALL contain no sub-module; the register file is instantiated beside it in the bench and at integration level.

Verification (DATA_WIDTH=8, ADDR_WIDTH=2, paired with a 4-entry register file)
REQ-032 LOAD base=0 count=4 data FF,EE,DD,CC, in_valid always 1 -> writes R0..R3 on 4 consecutive cycles, done pulses on cycle 5, busy falls after.
REQ-033 DUMP base=0 count=4, out_ready always 1 -> out_data FF,EE,DD,CC on 4 consecutive cycles, then done.
REQ-034 LOAD base=3 count=2 data 11,22 -> R3=11, R0=22 (wrap); a following DUMP base=3 count=2 -> 11,22.
REQ-035 DUMP with out_ready low for 3 cycles on word 2 -> out_data holds EE, no ptr advance, total sequence unchanged.
REQ-036 cmd_count=0 -> no write/read handshakes, done pulses the cycle after acceptance; cmd_count=7 -> exactly 4 words transferred.
REQ-037 Reset asserted after 2 of 4 LOAD words -> only 2 registers updated, next cycle IDLE with cmd_ready=1, done never pulses.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared enums for the register-file sequencer: command opcodes and FSM states.
package regfile_seq_pkg;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_DUMP = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_sequencer.sv
// Streams words into (LOAD) or out of (DUMP) an external register file, starting at a
// base address and wrapping modulo the depth; one-cycle done pulse per command.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_count,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  rf_w_en,
    output logic [ADDR_WIDTH-1:0] rf_w_addr,
    output logic [DATA_WIDTH-1:0] rf_w_data,
    output logic [ADDR_WIDTH-1:0] rf_r_addr,
    input  logic [DATA_WIDTH-1:0] rf_r_data,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                r_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_rem;

    logic [ADDR_WIDTH:0]   w_count_clamped;
    logic                  w_data_hs;

    // Counts beyond the depth would revisit addresses, so they are limited to one full pass.
    assign w_count_clamped = (cmd_count > DEPTH) ? DEPTH : cmd_count;
    assign w_data_hs       = ((r_state == LOAD) && in_valid) || ((r_state == DUMP) && out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_rem   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_ptr <= cmd_base;
                        r_rem <= w_count_clamped;
                        if (cmd_count == '0)
                            r_state <= DONE;
                        else if (op_e'(cmd_op) == OP_DUMP)
                            r_state <= DUMP;
                        else
                            r_state <= LOAD;
                    end
                end
                LOAD, DUMP: begin
                    if (w_data_hs) begin
                        r_ptr <= r_ptr + PTR_ONE;
                        r_rem <= r_rem - REM_ONE;
                        if (r_rem == REM_ONE)
                            r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Handshake-facing strobes are masked by reset so nothing transfers in the reset cycle.
    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign in_ready  = (r_state == LOAD) && !reset;
    assign out_valid = (r_state == DUMP) && !reset;
    assign done      = (r_state == DONE) && !reset;

    assign rf_w_en   = in_ready && in_valid;
    assign rf_w_addr = r_ptr;
    assign rf_w_data = in_data;

    assign rf_r_addr = (r_state == DUMP) ? r_ptr : '0;
    assign out_data  = rf_r_data;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench: directed vector table, reset-abort sequences, then random commands
// checked against an array model of the register file.
module tb_regfile_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [1:0] cmd_base;
    logic [2:0] cmd_count;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       rf_w_en;
    logic [1:0] rf_w_addr;
    logic [7:0] rf_w_data;
    logic [1:0] rf_r_addr;
    logic [7:0] rf_r_data;
    logic       busy;
    logic       done;

    regfile_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_base  (cmd_base),
        .cmd_count (cmd_count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rf_w_en   (rf_w_en),
        .rf_w_addr (rf_w_addr),
        .rf_w_data (rf_w_data),
        .rf_r_addr (rf_r_addr),
        .rf_r_data (rf_r_data),
        .busy      (busy),
        .done      (done)
    );

    // 4-entry register file paired with the sequencer
    logic [7:0] rf_mem [4];
    always @(posedge clk) if (rf_w_en) rf_mem[rf_w_addr] <= rf_w_data;
    assign rf_r_data = rf_mem[rf_r_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_rf [4];
    logic [7:0] got_data_q [$];
    logic [1:0] got_addr_q [$];
    int         done_cyc;
    bit         got_done;
    int         proto_err;

    typedef struct {
        logic            op;
        logic [1:0]      base;
        logic [2:0]      count;
        logic [3:0][7:0] wdata;
        int              stall_idx;
        int              stall_n;
        logic [3:0][7:0] exp_words;
        int              exp_done;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [3:0][7:0] w4(input logic [7:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issues one command at posedge+1 and runs it to completion; returns at posedge+1.
    task automatic run_cmd(input logic op, input logic [1:0] base, input logic [2:0] count,
                           input logic [3:0][7:0] wdata, input int stall_idx, input int stall_n,
                           input bit rnd);
        int cyc, widx, ridx, stall_cnt;
        bit hold_pending;
        logic [7:0] hold_data;
        got_data_q.delete();
        got_addr_q.delete();
        got_done = 0; done_cyc = -1; proto_err = 0;
        widx = 0; ridx = 0; stall_cnt = 0; hold_pending = 0; hold_data = '0;
        cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_count = count;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cyc = 0;
        while (!got_done && cyc < 60) begin
            cyc++;
            in_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data   = (widx < 4) ? wdata[widx] : 8'($urandom);
            out_ready = rnd ? ($urandom_range(0, 3) != 0)
                            : !(ridx == stall_idx && stall_cnt < stall_n);
            @(negedge clk);
            if (hold_pending) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_data);
                hold_pending = 0;
            end
            if (busy !== 1'b1) proto_err++;
            if (op == 1'b1 && (in_ready || rf_w_en)) proto_err++;
            if (op == 1'b0 && out_valid) proto_err++;
            if (!out_valid && rf_r_addr != 2'd0) proto_err++;
            if (rf_w_en && !in_valid) proto_err++;
            if (rf_w_en) begin
                got_data_q.push_back(rf_w_data);
                got_addr_q.push_back(rf_w_addr);
                widx++;
            end
            if (out_valid && out_ready) begin
                got_data_q.push_back(out_data);
                ridx++;
            end
            if (out_valid && !out_ready) begin
                hold_pending = 1;
                hold_data = out_data;
                stall_cnt++;
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
                if (in_ready || out_valid) proto_err++;
            end
            @(posedge clk); #1;
        end
        check("done_seen", got_done, 1);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("busy_after", busy, 0);
        check("ready_after", cmd_ready, 1);
        check("done_after", done, 0);
        @(posedge clk); #1;
    endtask

    task automatic verify(input logic op, input logic [1:0] base, input logic [2:0] count,
                          input logic [3:0][7:0] wdata, input bit use_tab,
                          input logic [3:0][7:0] tab_words, input int exp_done);
        int n;
        logic [1:0] a;
        logic [7:0] exp_w;
        n = (count > 3'd4) ? 4 : int'(count);
        check("n_words", got_data_q.size(), n);
        for (int k = 0; k < n; k++) begin
            a = base + 2'(k);
            if (op == 1'b0) begin
                exp_w = wdata[k];
                ref_rf[a] = wdata[k];
            end else begin
                exp_w = ref_rf[a];
            end
            if (use_tab) exp_w = tab_words[k];
            if (k < got_data_q.size()) begin
                check("word", got_data_q[k], exp_w);
                if (op == 1'b0) check("waddr", got_addr_q[k], a);
            end
        end
        if (exp_done >= 0) check("done_cyc", done_cyc, exp_done);
        check("protocol", proto_err, 0);
        for (int i = 0; i < 4; i++) check("rf_contents", rf_mem[i], ref_rf[i]);
        $display("CMD op=%s base=%0d count=%0d words=%0d done_cyc=%0d",
                 op ? "DUMP" : "LOAD", base, count, got_data_q.size(), done_cyc);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_count = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        vecs[0] = '{1'b0, 2'd0, 3'd4, w4(8'hFF, 8'hEE, 8'hDD, 8'hCC), -1, 0, w4(8'hFF, 8'hEE, 8'hDD, 8'hCC), 5};
        vecs[1] = '{1'b1, 2'd0, 3'd4, '0,                             -1, 0, w4(8'hFF, 8'hEE, 8'hDD, 8'hCC), 5};
        vecs[2] = '{1'b1, 2'd0, 3'd4, '0,                              1, 3, w4(8'hFF, 8'hEE, 8'hDD, 8'hCC), 8};
        vecs[3] = '{1'b0, 2'd3, 3'd2, w4(8'h11, 8'h22, 8'h00, 8'h00), -1, 0, w4(8'h11, 8'h22, 8'h00, 8'h00), 3};
        vecs[4] = '{1'b1, 2'd3, 3'd2, '0,                             -1, 0, w4(8'h11, 8'h22, 8'h00, 8'h00), 3};
        vecs[5] = '{1'b0, 2'd1, 3'd0, w4(8'h99, 8'h98, 8'h97, 8'h96), -1, 0, '0,                              1};
        vecs[6] = '{1'b1, 2'd1, 3'd7, '0,                             -1, 0, w4(8'hEE, 8'hDD, 8'h11, 8'h22), 5};
        vecs[7] = '{1'b0, 2'd2, 3'd7, w4(8'h01, 8'h02, 8'h03, 8'h04), -1, 0, w4(8'h01, 8'h02, 8'h03, 8'h04), 5};
        vecs[8] = '{1'b1, 2'd0, 3'd4, '0,                             -1, 0, w4(8'h03, 8'h04, 8'h01, 8'h02), 5};

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_rf_w_en", rf_w_en, 0);
        check("rst_rf_r_addr", rf_r_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].op, vecs[i].base, vecs[i].count, vecs[i].wdata,
                    vecs[i].stall_idx, vecs[i].stall_n, 1'b0);
            verify(vecs[i].op, vecs[i].base, vecs[i].count, vecs[i].wdata, 1'b1,
                   vecs[i].exp_words, vecs[i].exp_done);
        end

        // Reset after two of four LOAD words: only R0/R1 change, no done pulse
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = 2'd0; cmd_count = 3'd4;
        @(posedge clk); #1;
        cmd_valid = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        check("abort_done_w0", done, 0);
        @(posedge clk); #1;
        in_data = 8'hA5;
        @(posedge clk); #1;
        reset = 1'b1; in_data = 8'h77;
        @(negedge clk);
        check("abort_rst_w_en", rf_w_en, 0);
        check("abort_rst_in_ready", in_ready, 0);
        check("abort_rst_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_w_en", rf_w_en, 0);
        ref_rf[0] = 8'h5A;
        ref_rf[1] = 8'hA5;
        for (int i = 0; i < 4; i++) check("abort_rf", rf_mem[i], ref_rf[i]);
        $display("SEQ reset-abort LOAD after 2 words");
        @(posedge clk); #1;
        in_valid = 1'b0;

        // Reset during a stalled DUMP drops out_valid in that cycle
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = 2'd2; cmd_count = 3'd4; out_ready = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("dump_valid", out_valid, 1);
        check("dump_data", out_data, ref_rf[2]);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("dump_rst_valid", out_valid, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("dump_abort_ready", cmd_ready, 1);
        $display("SEQ reset-abort DUMP while stalled");
        @(posedge clk); #1;

        for (int t = 0; t < 40; t++) begin
            logic            op;
            logic [1:0]      base;
            logic [2:0]      count;
            logic [3:0][7:0] wd;
            op    = 1'($urandom_range(0, 1));
            base  = 2'($urandom_range(0, 3));
            count = 3'($urandom_range(0, 7));
            wd    = $urandom;
            run_cmd(op, base, count, wd, -1, 0, 1'b1);
            verify(op, base, count, wd, 1'b0, '0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
